// File: rtl/rgb_pwm_sequencer_if.sv
// Configuration port of rgb_pwm_sequencer: valid/ready table write bus.
// The master drives a table entry; the slave accepts it while idle.
interface rgb_pwm_sequencer_if #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned DUR_BITS = 8,
    parameter int unsigned IDX_BITS = 2
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [IDX_BITS-1:0] cfg_idx;
    logic [PWM_BITS-1:0] cfg_r;
    logic [PWM_BITS-1:0] cfg_g;
    logic [PWM_BITS-1:0] cfg_b;
    logic [DUR_BITS-1:0] cfg_dur;

    modport master (
        output cfg_valid, cfg_idx, cfg_r, cfg_g, cfg_b, cfg_dur,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_r, cfg_g, cfg_b, cfg_dur,
        output cfg_ready
    );
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// Plays a programmable table of RGB duty/duration steps as three PWM streams
// and drives the LED driver enable while playback is active.
module rgb_pwm_sequencer #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEPS    = 4,
    parameter int unsigned DUR_BITS = 8,
    parameter int unsigned IDX_BITS = $clog2(STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_pwm_sequencer_if.slave  cfg,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop_en,
    output logic                o_busy,
    output logic [IDX_BITS-1:0] o_step_idx,
    output logic                o_done,
    output logic                o_led_en,
    output logic                o_pwm_r,
    output logic                o_pwm_g,
    output logic                o_pwm_b
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              r_state;
    logic [PWM_BITS-1:0] r_cnt;
    logic [DUR_BITS-1:0] r_per;
    logic [IDX_BITS-1:0] r_step_idx;
    logic                r_busy, r_led_en, r_done, r_cfg_ready;
    logic                r_pwm_r, r_pwm_g, r_pwm_b;

    logic [PWM_BITS-1:0] r_tab_r   [STEPS];
    logic [PWM_BITS-1:0] r_tab_g   [STEPS];
    logic [PWM_BITS-1:0] r_tab_b   [STEPS];
    logic [DUR_BITS-1:0] r_tab_dur [STEPS];

    logic [DUR_BITS-1:0] w_dur;
    logic [DUR_BITS-1:0] w_dur_last;
    logic                w_cnt_wrap;
    logic                w_step_end;
    logic                w_last_step;

    // A zero duration plays as a single PWM period.
    assign w_dur       = r_tab_dur[r_step_idx];
    assign w_dur_last  = (w_dur == '0) ? '0 : w_dur - 1'b1;
    assign w_cnt_wrap  = &r_cnt;
    assign w_step_end  = w_cnt_wrap && (r_per == w_dur_last);
    assign w_last_step = (r_step_idx == IDX_BITS'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_per       <= '0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_led_en    <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_pwm_r     <= 1'b0;
            r_pwm_g     <= 1'b0;
            r_pwm_b     <= 1'b0;
            for (int i = 0; i < int'(STEPS); i++) begin
                r_tab_r[i]   <= '0;
                r_tab_g[i]   <= '0;
                r_tab_b[i]   <= '0;
                r_tab_dur[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cfg.cfg_valid) begin
                        r_tab_r[cfg.cfg_idx]   <= cfg.cfg_r;
                        r_tab_g[cfg.cfg_idx]   <= cfg.cfg_g;
                        r_tab_b[cfg.cfg_idx]   <= cfg.cfg_b;
                        r_tab_dur[cfg.cfg_idx] <= cfg.cfg_dur;
                    end
                    if (i_start && !i_stop) begin
                        r_state     <= StRun;
                        r_cnt       <= '0;
                        r_per       <= '0;
                        r_step_idx  <= '0;
                        r_busy      <= 1'b1;
                        r_led_en    <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_step_idx  <= '0;
                        r_busy      <= 1'b0;
                        r_led_en    <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        r_pwm_r     <= 1'b0;
                        r_pwm_g     <= 1'b0;
                        r_pwm_b     <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_pwm_r <= (r_cnt < r_tab_r[r_step_idx]);
                        r_pwm_g <= (r_cnt < r_tab_g[r_step_idx]);
                        r_pwm_b <= (r_cnt < r_tab_b[r_step_idx]);
                        if (w_step_end) begin
                            r_per <= '0;
                            if (!w_last_step) begin
                                r_step_idx <= r_step_idx + 1'b1;
                            end else if (i_loop_en) begin
                                r_step_idx <= '0;
                            end else begin
                                r_state     <= StIdle;
                                r_step_idx  <= '0;
                                r_busy      <= 1'b0;
                                r_led_en    <= 1'b0;
                                r_cfg_ready <= 1'b1;
                                r_done      <= 1'b1;
                                r_pwm_r     <= 1'b0;
                                r_pwm_g     <= 1'b0;
                                r_pwm_b     <= 1'b0;
                            end
                        end else if (w_cnt_wrap) begin
                            r_per <= r_per + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign o_busy        = r_busy;
    assign o_step_idx    = r_step_idx;
    assign o_done        = r_done;
    assign o_led_en      = r_led_en;
    assign o_pwm_r       = r_pwm_r;
    assign o_pwm_g       = r_pwm_g;
    assign o_pwm_b       = r_pwm_b;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer: expected outputs come from a
// time-since-start model of the step table (PWM_BITS=4, STEPS=2).
module tb_rgb_pwm_sequencer;
    localparam int PW  = 4;
    localparam int ST  = 2;
    localparam int DB  = 8;
    localparam int IB  = 1;
    localparam int PER = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic busy, done, led_en, pwm_r, pwm_g, pwm_b;
    logic [IB-1:0] step_idx;

    int total = 0;
    int bad = 0;
    int m_r[ST], m_g[ST], m_b[ST], m_d[ST];

    always #5 clk = ~clk;

    rgb_pwm_sequencer_if #(.PWM_BITS(PW), .DUR_BITS(DB), .IDX_BITS(IB)) cfg_if ();

    rgb_pwm_sequencer #(.PWM_BITS(PW), .STEPS(ST), .DUR_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg_if),
        .i_start    (start),
        .i_stop     (stop),
        .i_loop_en  (loop_en),
        .o_busy     (busy),
        .o_step_idx (step_idx),
        .o_done     (done),
        .o_led_en   (led_en),
        .o_pwm_r    (pwm_r),
        .o_pwm_g    (pwm_g),
        .o_pwm_b    (pwm_b)
    );

    function automatic logic [7:0] obs();
        return {busy, led_en, done, cfg_if.cfg_ready, step_idx, pwm_r, pwm_g, pwm_b};
    endfunction

    function automatic logic [7:0] idle_vec(input bit d);
        return {1'b0, 1'b0, d, 1'b1, 1'b0, 3'b000};
    endfunction

    function automatic int step_len(input int i);
        return ((m_d[i] == 0) ? 1 : m_d[i]) * PER;
    endfunction

    function automatic int total_len();
        int t = 0;
        for (int i = 0; i < ST; i++) t += step_len(i);
        return t;
    endfunction

    // Step holding time offset t within one pass of the table.
    function automatic int step_of(input int t);
        int acc = 0;
        for (int i = 0; i < ST; i++) begin
            if (t < acc + step_len(i)) return i;
            acc += step_len(i);
        end
        return ST - 1;
    endfunction

    function automatic void model_write(input int i, input int r, input int g, input int b,
                                        input int d);
        m_r[i] = r; m_g[i] = g; m_b[i] = b; m_d[i] = d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ST; i++) model_write(i, 0, 0, 0, 0);
    endfunction

    task automatic write_entry(input int i, input int r, input int g, input int b, input int d);
        @(negedge clk);
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_ready idx %0d: got %b want 1", i, cfg_if.cfg_ready);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_idx   = IB'(i);
        cfg_if.cfg_r     = PW'(r);
        cfg_if.cfg_g     = PW'(g);
        cfg_if.cfg_b     = PW'(b);
        cfg_if.cfg_dur   = DB'(d);
        @(posedge clk);
        model_write(i, r, g, b, d);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Starts playback and checks every output on each cycle k after the start edge.
    task automatic play(input bit lp, input int ncyc, input int stop_at, input bit hold_valid,
                        input bit rand_start, input string name);
        int T, s, s2, c;
        bit written, running, stopped, er, eg, eb;
        logic [7:0] exp;
        T = total_len();
        written = 1'b0;
        @(negedge clk);
        start = 1'b1; stop = 1'b0; loop_en = lp;
        @(posedge clk); #1;
        for (int k = 0; k < ncyc; k++) begin
            stopped = (stop_at >= 0) && (k > stop_at);
            if (stopped) begin
                exp = idle_vec(1'b0);
            end else if (!lp && k >= T) begin
                exp = idle_vec(k == T);
            end else begin
                s = step_of(lp ? k % T : k);
                er = 1'b0; eg = 1'b0; eb = 1'b0;
                if (k > 0) begin
                    s2 = step_of(lp ? (k - 1) % T : k - 1);
                    c  = (k - 1) % PER;
                    er = c < m_r[s2]; eg = c < m_g[s2]; eb = c < m_b[s2];
                end
                exp = {1'b1, 1'b1, 1'b0, 1'b0, IB'(s), er, eg, eb};
            end
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL %s cycle %0d: got %b want %b (busy led done rdy idx r g b)",
                         name, k, obs(), exp);
            end
            running = !stopped && (lp || k < T);
            @(negedge clk);
            start = (rand_start && running) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (k == stop_at);
            cfg_if.cfg_valid = 1'b0;
            if (hold_valid && !written) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_idx   = 1'b1;
                cfg_if.cfg_r     = 4'd3;
                cfg_if.cfg_g     = 4'd7;
                cfg_if.cfg_b     = 4'd9;
                cfg_if.cfg_dur   = 8'd0;
                if (!running) begin
                    model_write(1, 3, 7, 9, 0);
                    written = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs() !== idle_vec(1'b0)) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", obs(), idle_vec(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single_step();
        write_entry(0, 5, 0, 15, 2);
        write_entry(1, 0, 15, 0, 1);
        play(1'b0, 52, -1, 1'b0, 1'b0, "single_step");
    endtask

    task automatic test_loop();
        play(1'b1, 110, -1, 1'b0, 1'b1, "loop");
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_dur_zero();
        write_entry(0, 5, 0, 15, 0);
        play(1'b0, 36, -1, 1'b0, 1'b0, "dur_zero");
    endtask

    task automatic test_handshake();
        play(1'b0, 40, -1, 1'b1, 1'b1, "handshake_run");
        play(1'b0, 36, -1, 1'b0, 1'b0, "handshake_new_entry");
    endtask

    task automatic test_stop();
        write_entry(0, 5, 0, 15, 2);
        write_entry(1, 0, 15, 0, 1);
        play(1'b0, 30, 20, 1'b0, 1'b0, "stop_mid");
        play(1'b0, 52, 47, 1'b0, 1'b0, "stop_at_end");
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if (obs() !== idle_vec(1'b0)) begin
                bad++;
                $display("FAIL start_stop_idle cycle %0d: got %b want %b",
                         k, obs(), idle_vec(1'b0));
            end
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_random();
        int T, sa;
        bit lp;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < ST; i++)
                write_entry(i, $urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 2));
            T  = total_len();
            lp = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T - 1)) : -1;
            if (lp) begin
                play(1'b1, 2 * T + 5, sa, 1'b0, 1'b1, "random_loop");
                @(negedge clk); stop = 1'b1;
                @(negedge clk); stop = 1'b0;
            end else begin
                play(1'b0, T + 3, sa, 1'b0, 1'b1, "random_once");
            end
        end
    endtask

    task automatic test_reset_mid_run();
        write_entry(0, 9, 4, 12, 1);
        write_entry(1, 2, 14, 6, 1);
        @(negedge clk);
        start = 1'b1; loop_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (obs() !== idle_vec(1'b0)) begin
                bad++;
                $display("FAIL reset_mid_run edge %0d: got %b want %b",
                         k, obs(), idle_vec(1'b0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        loop_en = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total++;
        if (obs() !== idle_vec(1'b0)) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs(), idle_vec(1'b0));
        end
        play(1'b0, 36, -1, 1'b0, 1'b0, "after_reset_cleared");
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_idx   = '0;
        cfg_if.cfg_r     = '0;
        cfg_if.cfg_g     = '0;
        cfg_if.cfg_b     = '0;
        cfg_if.cfg_dur   = '0;
        test_reset();
        test_single_step();
        test_loop();
        test_dur_zero();
        test_handshake();
        test_stop();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
